// File: rtl/drop_column_if.sv
// Bundles the move-input and display-side signals of one board column.
// The master modport drives moves and clears; the slave side is the column controller.
interface drop_column_if #(
  parameter int ROWS = 6
) ();
  localparam int RW = $clog2(ROWS);

  logic              clear;
  logic              drop;
  logic [1:0]        player;
  logic              step;
  logic [2*ROWS-1:0] cells;
  logic              busy;
  logic              full;
  logic              placed;
  logic [RW-1:0]     placed_row;
  logic              reject;

  modport master (
    output clear, drop, player, step,
    input  cells, busy, full, placed, placed_row, reject
  );

  modport slave (
    input  clear, drop, player, step,
    output cells, busy, full, placed, placed_row, reject
  );
endinterface

// File: rtl/drop_column.sv
// One Connect-Four column: stores landed tokens and animates a dropped token
// falling one row per step tick until it reaches the bottom or another token.
module drop_column #(
  parameter int ROWS = 6
) (
  input  logic          clock,
  input  logic          reset,
  drop_column_if.slave  bus
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic {IDLE, FALLING} state_t;

  state_t            state_q, state_d;
  logic [2*ROWS-1:0] stored_q, stored_d;
  logic [RW-1:0]     pos_q, pos_d;
  logic [1:0]        colour_q, colour_d;
  logic              placed_q, placed_d;
  logic [RW-1:0]     placed_row_q, placed_row_d;
  logic              reject_q, reject_d;

  // occ_ext[ROWS] is a virtual floor so the bottom row lands like any other.
  logic [ROWS:0]     occ_ext;
  logic [2*ROWS-1:0] overlay;
  logic [RW:0]       below_idx;
  logic              blocked;
  logic              player_ok;

  assign occ_ext[ROWS] = 1'b1;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign occ_ext[gi] = |stored_q[2*gi +: 2];
    assign overlay[2*gi +: 2] =
      (state_q == FALLING && pos_q == RW'(gi)) ? colour_q : 2'b00;
  end

  assign below_idx = {1'b0, pos_q} + (RW+1)'(1);
  assign blocked   = occ_ext[below_idx];
  assign player_ok = (bus.player == 2'b10) || (bus.player == 2'b01);

  always_comb begin
    state_d      = state_q;
    stored_d     = stored_q;
    pos_d        = pos_q;
    colour_d     = colour_q;
    placed_d     = 1'b0;
    placed_row_d = placed_row_q;
    reject_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.drop) begin
          if (player_ok && !occ_ext[0]) begin
            state_d  = FALLING;
            pos_d    = '0;
            colour_d = bus.player;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      FALLING: begin
        // No queuing: any drop while a token is in flight is refused.
        reject_d = bus.drop;
        if (bus.step) begin
          if (blocked) begin
            stored_d[2*pos_q +: 2] = colour_q;
            placed_d               = 1'b1;
            placed_row_d           = pos_q;
            state_d                = IDLE;
          end else begin
            pos_d = pos_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      state_q      <= IDLE;
      stored_q     <= '0;
      pos_q        <= '0;
      colour_q     <= 2'b00;
      placed_q     <= 1'b0;
      placed_row_q <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stored_q     <= stored_d;
      pos_q        <= pos_d;
      colour_q     <= colour_d;
      placed_q     <= placed_d;
      placed_row_q <= placed_row_d;
      reject_q     <= reject_d;
    end
  end

  assign bus.cells      = stored_q | overlay;
  assign bus.busy       = (state_q == FALLING);
  assign bus.full       = occ_ext[0];
  assign bus.placed     = placed_q;
  assign bus.placed_row = placed_row_q;
  assign bus.reject     = reject_q;
endmodule

// File: tb/tb_drop_column.sv
// Directed bench for a 6-row drop_column: landing, stacking, full column,
// invalid colours, clear mid-fall and drops refused during a fall.
module tb_drop_column;
  localparam int ROWS = 6;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  drop_column_if #(.ROWS(ROWS)) bus ();

  drop_column #(.ROWS(ROWS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drop_token(input logic [1:0] colour);
    bus.drop   = 1'b1;
    bus.player = colour;
    cyc();
    bus.drop   = 1'b0;
  endtask

  task automatic do_steps(input int n);
    bus.step = 1'b1;
    repeat (n) cyc();
    bus.step = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.clear  = 1'b0;
    bus.drop   = 1'b0;
    bus.player = 2'b00;
    bus.step   = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_cells", 32'(bus.cells), 32'h000);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_placed", 32'(bus.placed), 0);
    check("rst_reject", 32'(bus.reject), 0);
    check("rst_prow", 32'(bus.placed_row), 0);

    // 1: green falls to bottom after 6 ticks
    drop_token(2'b10);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_row0", 32'(bus.cells), 32'h002);
    do_steps(5);
    check("t1_row5_fall", 32'(bus.cells), 32'h800);
    check("t1_busy5", 32'(bus.busy), 1);
    check("t1_noplace", 32'(bus.placed), 0);
    do_steps(1);
    check("t1_placed", 32'(bus.placed), 1);
    check("t1_prow", 32'(bus.placed_row), 5);
    check("t1_busy_off", 32'(bus.busy), 0);
    check("t1_cells", 32'(bus.cells), 32'h800);
    cyc();
    check("t1_pulse_end", 32'(bus.placed), 0);
    check("t1_prow_hold", 32'(bus.placed_row), 5);

    // 2: red stacks on green at row 4
    drop_token(2'b01);
    check("t2_row0", 32'(bus.cells), 32'h801);
    do_steps(4);
    check("t2_row4_fall", 32'(bus.cells), 32'h900);
    do_steps(1);
    check("t2_placed", 32'(bus.placed), 1);
    check("t2_prow", 32'(bus.placed_row), 4);
    check("t2_cells", 32'(bus.cells), 32'h900);

    // 3: fill rows 3..0, then a 7th drop is refused
    drop_token(2'b10); do_steps(4);
    check("t3_prow3", 32'(bus.placed_row), 3);
    check("t3_cells3", 32'(bus.cells), 32'h980);
    drop_token(2'b01); do_steps(3);
    check("t3_prow2", 32'(bus.placed_row), 2);
    check("t3_cells2", 32'(bus.cells), 32'h990);
    drop_token(2'b10); do_steps(2);
    check("t3_prow1", 32'(bus.placed_row), 1);
    check("t3_cells1", 32'(bus.cells), 32'h998);
    check("t3_notfull", 32'(bus.full), 0);
    drop_token(2'b01);
    check("t3_full_falling", 32'(bus.full), 0);
    check("t3_cells_falling", 32'(bus.cells), 32'h999);
    do_steps(1);
    check("t3_prow0", 32'(bus.placed_row), 0);
    check("t3_placed0", 32'(bus.placed), 1);
    check("t3_full", 32'(bus.full), 1);
    drop_token(2'b10);
    check("t3_reject", 32'(bus.reject), 1);
    check("t3_busy", 32'(bus.busy), 0);
    check("t3_cells_kept", 32'(bus.cells), 32'h999);
    cyc();
    check("t3_reject_end", 32'(bus.reject), 0);

    // 4: clear, then invalid colours are refused
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    check("t4_clr_cells", 32'(bus.cells), 32'h000);
    check("t4_clr_full", 32'(bus.full), 0);
    check("t4_clr_prow", 32'(bus.placed_row), 0);
    drop_token(2'b11);
    check("t4_rej11", 32'(bus.reject), 1);
    check("t4_busy11", 32'(bus.busy), 0);
    drop_token(2'b00);
    check("t4_rej00", 32'(bus.reject), 1);
    check("t4_busy00", 32'(bus.busy), 0);
    check("t4_cells", 32'(bus.cells), 32'h000);

    // 5: clear while falling discards the token
    drop_token(2'b10);
    do_steps(2);
    check("t5_pos2", 32'(bus.cells), 32'h020);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    check("t5_cells", 32'(bus.cells), 32'h000);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_placed", 32'(bus.placed), 0);
    cyc();
    check("t5_placed_after", 32'(bus.placed), 0);

    // 6: drop during fall is refused, token continues and lands
    drop_token(2'b01);
    do_steps(1);
    check("t6_pos1", 32'(bus.cells), 32'h004);
    drop_token(2'b10);
    check("t6_reject", 32'(bus.reject), 1);
    check("t6_busy", 32'(bus.busy), 1);
    check("t6_cells", 32'(bus.cells), 32'h004);
    do_steps(4);
    check("t6_pos5", 32'(bus.cells), 32'h400);
    check("t6_reject_end", 32'(bus.reject), 0);
    do_steps(1);
    check("t6_placed", 32'(bus.placed), 1);
    check("t6_prow", 32'(bus.placed_row), 5);
    check("t6_land_cells", 32'(bus.cells), 32'h400);

    // step alone in IDLE does nothing; drop+step together accepts drop only
    do_steps(2);
    check("idle_step_cells", 32'(bus.cells), 32'h400);
    check("idle_step_busy", 32'(bus.busy), 0);
    bus.step = 1'b1;
    drop_token(2'b01);
    bus.step = 1'b0;
    check("dropstep_pos0", 32'(bus.cells), 32'h401);
    check("dropstep_busy", 32'(bus.busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
